// File: rtl/prim_fifo_ptr_ctrl_pkg.sv
// Shared helpers for the FIFO pointer/occupancy controller.
`default_nettype none

package prim_fifo_ptr_ctrl_pkg;

   // Index width never collapses to zero, so a single-entry FIFO still has a 1-bit idx field.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/prim_fifo_ptr_cnt.sv
// Single wrap-bit FIFO pointer with Depth-aware wrap and optional inverted shadow check.
`default_nettype none

module prim_fifo_ptr_cnt
   import prim_fifo_ptr_ctrl_pkg::*;
#(
   parameter int unsigned Depth  = 4,
   parameter bit          Secure = 1'b0,
   localparam int unsigned IdxW  = idx_width(Depth),
   localparam int unsigned PtrW  = IdxW + 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clr_i,
   input  logic            incr_i,
   output logic [PtrW-1:0] ptr_o,
   output logic            err_o
);

   localparam logic [IdxW-1:0] LastIdx  = IdxW'(Depth - 1);
   localparam logic [IdxW:0]   DepthExt = (IdxW + 1)'(Depth);

   logic [PtrW-1:0] ptr_q;
   logic [PtrW-1:0] ptr_d;
   logic [PtrW-1:0] step;
   logic [IdxW-1:0] idx;
   logic            wrap;

   assign idx  = ptr_q[IdxW-1:0];
   assign wrap = ptr_q[PtrW-1];

   always_comb begin
      step = ptr_q;
      if (idx == LastIdx) begin
         step = {~wrap, {IdxW{1'b0}}};
      end else begin
         step = {wrap, idx + 1'b1};
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (clr_i) begin
         ptr_d = '0;
      end else if (incr_i) begin
         ptr_d = step;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

   generate
      if (Secure) begin : g_shadow
         logic [PtrW-1:0] shadow_q;

         // Shadow tracks ~ptr in lockstep; any divergence or out-of-range index is a fault.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               shadow_q <= '1;
            end else begin
               shadow_q <= ~ptr_d;
            end
         end

         assign err_o = (shadow_q != ~ptr_q) | ({1'b0, idx} >= DepthExt);
      end else begin : g_no_shadow
         assign err_o = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/prim_fifo_ptr_ctrl.sv
// FIFO pointer and occupancy controller for arbitrary depth: acks, flags, depth and sticky error.
`default_nettype none

module prim_fifo_ptr_ctrl
   import prim_fifo_ptr_ctrl_pkg::*;
#(
   parameter int unsigned Depth            = 4,
   parameter int unsigned AlmostFullThresh = Depth - 1,
   parameter bit          Secure           = 1'b0,
   localparam int unsigned IdxW            = idx_width(Depth),
   localparam int unsigned PtrW            = IdxW + 1,
   localparam int unsigned DepthW          = $clog2(Depth + 1)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_i,
   input  logic              push_i,
   input  logic              pop_i,
   output logic              push_ack_o,
   output logic              pop_ack_o,
   output logic [PtrW-1:0]   wptr_o,
   output logic [PtrW-1:0]   rptr_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic [DepthW-1:0] depth_o,
   output logic              err_o
);

   localparam logic [DepthW-1:0] DepthVal  = DepthW'(Depth);
   localparam logic [DepthW-1:0] ThreshVal = DepthW'(AlmostFullThresh);

   logic [PtrW-1:0]   wptr;
   logic [PtrW-1:0]   rptr;
   logic [IdxW-1:0]   widx;
   logic [IdxW-1:0]   ridx;
   logic              wrap_eq;
   logic              full;
   logic              empty;
   logic [DepthW-1:0] depth;
   logic              werr;
   logic              rerr;
   logic              err_q;

   prim_fifo_ptr_cnt #(
      .Depth  (Depth),
      .Secure (Secure)
   ) u_wptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .incr_i (push_ack_o),
      .ptr_o  (wptr),
      .err_o  (werr)
   );

   prim_fifo_ptr_cnt #(
      .Depth  (Depth),
      .Secure (Secure)
   ) u_rptr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i),
      .incr_i (pop_ack_o),
      .ptr_o  (rptr),
      .err_o  (rerr)
   );

   assign widx    = wptr[IdxW-1:0];
   assign ridx    = rptr[IdxW-1:0];
   assign wrap_eq = (wptr[PtrW-1] == rptr[PtrW-1]);
   assign empty   = (wptr == rptr);
   assign full    = (widx == ridx) & ~wrap_eq;

   // Differing wrap bits mean the writer is one lap ahead, so add a full Depth back in.
   always_comb begin
      depth = '0;
      if (wrap_eq) begin
         depth = DepthW'(widx) - DepthW'(ridx);
      end else begin
         depth = DepthVal - DepthW'(ridx) + DepthW'(widx);
      end
   end

   assign push_ack_o = push_i & ~full & ~clr_i;
   assign pop_ack_o  = pop_i & ~empty & ~clr_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_q | (push_i & full) | (pop_i & empty) | werr | rerr;
      end
   end

   assign wptr_o        = wptr;
   assign rptr_o        = rptr;
   assign full_o        = full;
   assign empty_o       = empty;
   assign almost_full_o = (depth >= ThreshVal);
   assign depth_o       = depth;
   assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_prim_fifo_ptr_ctrl.sv
// Self-checking bench: directed cases plus random traffic against an occupancy/position model.
`default_nettype none

module tb_prim_fifo_ptr_ctrl;

   localparam int D  = 5;
   localparam int IW = 3;
   localparam int PW = 4;
   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          clr_i, push_i, pop_i;
   logic          push_ack_o, pop_ack_o, full_o, empty_o, almost_full_o, err_o;
   logic [PW-1:0] wptr_o, rptr_o;
   logic [DW-1:0] depth_o;

   logic          clr1, push1, pop1;
   logic          d1_push_ack, d1_pop_ack, d1_full, d1_empty, d1_af, d1_err;
   logic [1:0]    d1_wptr, d1_rptr;
   logic [0:0]    d1_depth;

   int n_vec = 0;
   int n_err = 0;
   bit check_en = 1'b0;
   bit shadow_forced = 1'b0;

   // Model: pointer positions 0..2D-1 (lap-aware), sticky error.
   int wp, rp;
   bit err_m;

   always #5 clk = ~clk;

   prim_fifo_ptr_ctrl #(.Depth(D), .AlmostFullThresh(4), .Secure(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .push_i(push_i), .pop_i(pop_i),
      .push_ack_o(push_ack_o), .pop_ack_o(pop_ack_o), .wptr_o(wptr_o), .rptr_o(rptr_o),
      .full_o(full_o), .empty_o(empty_o), .almost_full_o(almost_full_o),
      .depth_o(depth_o), .err_o(err_o)
   );

   prim_fifo_ptr_ctrl #(.Depth(1), .AlmostFullThresh(1), .Secure(1'b0)) dut1 (
      .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr1), .push_i(push1), .pop_i(pop1),
      .push_ack_o(d1_push_ack), .pop_ack_o(d1_pop_ack), .wptr_o(d1_wptr), .rptr_o(d1_rptr),
      .full_o(d1_full), .empty_o(d1_empty), .almost_full_o(d1_af),
      .depth_o(d1_depth), .err_o(d1_err)
   );

   function automatic int occ(input int w, input int r);
      return (w - r + 2 * D) % (2 * D);
   endfunction

   function automatic logic [PW-1:0] enc(input int p);
      int v;
      v = ((p >= D) ? (1 << IW) : 0) + (p % D);
      return PW'(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         wp    <= 0;
         rp    <= 0;
         err_m <= 1'b0;
      end else begin
         if ((push_i && occ(wp, rp) == D) || (pop_i && occ(wp, rp) == 0) || shadow_forced)
            err_m <= 1'b1;
         if (clr_i) begin
            wp <= 0;
            rp <= 0;
         end else begin
            if (push_i && occ(wp, rp) != D) wp <= (wp + 1) % (2 * D);
            if (pop_i && occ(wp, rp) != 0)  rp <= (rp + 1) % (2 * D);
         end
      end
   end

   always @(negedge clk) begin
      if (check_en && rst_ni) begin
         chk("push_ack", 32'(push_ack_o), 32'(push_i && occ(wp, rp) != D && !clr_i));
         chk("pop_ack",  32'(pop_ack_o),  32'(pop_i && occ(wp, rp) != 0 && !clr_i));
         chk("wptr",     32'(wptr_o),     32'(enc(wp)));
         chk("rptr",     32'(rptr_o),     32'(enc(rp)));
         chk("full",     32'(full_o),     32'(occ(wp, rp) == D));
         chk("empty",    32'(empty_o),    32'(occ(wp, rp) == 0));
         chk("almost_full", 32'(almost_full_o), 32'(occ(wp, rp) >= 4));
         chk("depth",    32'(depth_o),    32'(occ(wp, rp)));
         chk("err",      32'(err_o),      32'(err_m));
      end
   end

   task automatic tick(input logic p, input logic q, input logic c);
      @(posedge clk);
      #1;
      push_i = p;
      pop_i  = q;
      clr_i  = c;
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_wptr", 32'(wptr_o), 32'd0);
      chk("rst_err",  32'(err_o),  32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      #1 rst_ni = 1'b1;
   endtask

   initial begin
      logic [PW-1:0] wexp [4];
      wexp = '{4'd1, 4'd2, 4'd3, 4'd4};
      rst_ni = 1'b0;
      push_i = 0; pop_i = 0; clr_i = 0;
      push1 = 0; pop1 = 0; clr1 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_ni   = 1'b1;
      check_en = 1'b1;
      chk("reset_depth", 32'(depth_o), 32'd0);
      chk("reset_full",  32'(full_o),  32'd0);
      chk("reset_af",    32'(almost_full_o), 32'd0);
      chk("reset_err",   32'(err_o),   32'd0);

      // Fill Depth=5 and exercise Depth=1 in parallel.
      push1 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1, 0, 0);
         if (i > 0) chk("fill_wptr", 32'(wptr_o), 32'(wexp[i-1]));
         if (i == 3) chk("af_at_3", 32'(almost_full_o), 32'd0);
         if (i == 4) chk("af_at_4", 32'(almost_full_o), 32'd1);
         if (i == 1) begin
            chk("d1_wptr", 32'(d1_wptr), 32'd2);
            chk("d1_full", 32'(d1_full), 32'd1);
            push1 = 1'b0;
            pop1  = 1'b1;
         end
         if (i == 2) begin
            chk("d1_rptr",  32'(d1_rptr),  32'd2);
            chk("d1_empty", 32'(d1_empty), 32'd1);
            pop1 = 1'b0;
         end
      end
      tick(1, 1, 0);
      chk("full_wptr",   32'(wptr_o),   32'd8);
      chk("full_flag",   32'(full_o),   32'd1);
      chk("full_depth",  32'(depth_o),  32'd5);
      chk("full_pop_ack",  32'(pop_ack_o),  32'd1);
      chk("full_push_ack", 32'(push_ack_o), 32'd0);
      tick(0, 0, 0);
      chk("after_rptr",  32'(rptr_o),  32'd1);
      chk("after_depth", 32'(depth_o), 32'd4);
      chk("after_err",   32'(err_o),   32'd1);
      pulse_reset();

      // Underflow from reset, err survives clr.
      tick(0, 1, 0);
      chk("uf_pop_ack", 32'(pop_ack_o), 32'd0);
      tick(0, 0, 1);
      chk("uf_rptr", 32'(rptr_o), 32'd0);
      chk("uf_err",  32'(err_o),  32'd1);
      tick(0, 0, 0);
      chk("clr_keeps_err", 32'(err_o), 32'd1);
      pulse_reset();

      // Steady push+pop at 3 entries across the wrap.
      repeat (3) tick(1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick(1, 1, 0);
         chk("steady_depth", 32'(depth_o), 32'd3);
      end
      tick(0, 0, 0);
      chk("steady_wptr", 32'(wptr_o), 32'd3);
      chk("steady_rptr", 32'(rptr_o), 32'd0);
      chk("steady_err",  32'(err_o),  32'd0);

      // clr together with push.
      tick(1, 0, 1);
      chk("clr_push_ack", 32'(push_ack_o), 32'd0);
      tick(0, 0, 0);
      chk("clr_wptr",  32'(wptr_o),  32'd0);
      chk("clr_rptr",  32'(rptr_o),  32'd0);
      chk("clr_empty", 32'(empty_o), 32'd1);

      // Random traffic with drifting push/pop bias.
      for (int i = 0; i < 1500; i++) begin
         int bias;
         bias = 20 + 20 * ((i / 100) % 4);
         tick(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < 50),
              ($urandom_range(0, 63) == 0));
      end
      tick(0, 0, 0);
      pulse_reset();

      // Corrupt a shadow register; err must rise while pointers keep moving.
      tick(1, 0, 0);
      force dut.u_wptr.g_shadow.shadow_q = '0;
      shadow_forced = 1'b1;
      tick(1, 0, 0);
      chk("sec_err", 32'(err_o), 32'd1);
      for (int i = 0; i < 20; i++) begin
         tick(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0);
      end
      release dut.u_wptr.g_shadow.shadow_q;
      shadow_forced = 1'b0;
      tick(0, 0, 0);
      pulse_reset();
      tick(0, 0, 0);
      tick(0, 0, 0);
      chk("final_err", 32'(err_o), 32'd0);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
